pic_priority_unit: RTL and testbench

- Interrupt-request front end of the 8259 PIC; sits directly upstream of the PIC control unit.
- Captures IR0–IR7 into the IRR, applies the OCW1 mask, and resolves priority against the ISR in fully-nested or rotating mode.
- Drives INTERNAL_INT and IR_NUM to the control unit, sets and clears ISR bits across the INTA_ pulse pair and EOI commands, and supplies IRR/ISR readback.

---
 rtl/pic_pkg.sv | 22 ++
 rtl/pic_priority_resolver.sv | 13 +
 rtl/pic_priority_unit.sv | 154 +++++++++++++++
 tb/tb_pic_priority_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and the rotating-priority search used by the 8259 priority unit.
package pic_pkg;

  localparam int NUM_IR = 8;

  typedef logic [2:0] level_t;

  typedef enum logic {IDLE, ACK1} pic_state_e;

  // Walks from lowest to highest priority so the last hit is the winner.
  function automatic logic [3:0] rot_index(input logic [NUM_IR-1:0] vec, input level_t lp);
    logic [3:0] res;
    level_t     idx;
    res = 4'b0;
    for (int k = NUM_IR; k >= 1; k--) begin
      idx = lp + level_t'(k);
      if (vec[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority encoder: highest set bit starting after lp_i.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec_i,
  input  level_t            lp_i,
  output logic              found_o,
  output level_t            idx_o
);

  assign {found_o, idx_o} = rot_index(vec_i, lp_i);

endmodule

// File: rtl/pic_priority_unit.sv
// 8259 interrupt front end: IRR capture, masking, priority resolution, ISR and EOI handling.
module pic_priority_unit
  import pic_pkg::*;
#(
  parameter int     SYNC_STAGES = 2,
  parameter level_t RESET_LP    = 3'd7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IR_IN,
  input  logic       LEVEL,
  input  logic [7:0] interrupt_mask,
  input  logic       INTA_,
  input  logic       AEOI,
  input  logic       R,
  input  logic       EOI_CMD,
  input  logic       SEOI_CMD,
  input  logic [2:0] EOI_LEVEL,
  input  logic       RIRR,
  input  logic       RISR,
  output logic       INTERNAL_INT,
  output logic [2:0] IR_NUM,
  output logic [7:0] IRR_OUT,
  output logic [7:0] ISR_OUT,
  output logic [7:0] READ_DATA
);

  logic [SYNC_STAGES-1:0][7:0] ir_sync_q;
  logic [SYNC_STAGES-1:0]      inta_sync_q;
  logic [7:0] ir_prev_q;
  logic       inta_prev_q;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  level_t     lp_q, lp_d;
  level_t     ir_num_q, ir_num_d;
  logic       int_q, int_d;
  logic       spur_q, spur_d;
  pic_state_e state_q, state_d;

  logic [7:0] ir_s;
  logic       inta_s;
  logic       inta_fall;
  logic [7:0] cand;
  logic       win_found, top_found;
  level_t     win_idx, top_idx;
  level_t     win_rank, top_rank;

  assign ir_s      = ir_sync_q[SYNC_STAGES-1];
  assign inta_s    = inta_sync_q[SYNC_STAGES-1];
  assign inta_fall = inta_prev_q & ~inta_s;
  assign cand      = irr_q & ~interrupt_mask;

  pic_priority_resolver u_cand_res (
    .vec_i  (cand),
    .lp_i   (lp_q),
    .found_o(win_found),
    .idx_o  (win_idx)
  );

  pic_priority_resolver u_isr_res (
    .vec_i  (isr_q),
    .lp_i   (lp_q),
    .found_o(top_found),
    .idx_o  (top_idx)
  );

  // Distance from the highest-priority slot; smaller means more urgent.
  assign win_rank = win_idx - lp_q - 3'd1;
  assign top_rank = top_idx - lp_q - 3'd1;

  always_comb begin
    state_d  = state_q;
    isr_d    = isr_q;
    lp_d     = lp_q;
    ir_num_d = ir_num_q;
    spur_d   = spur_q;
    int_d    = 1'b0;

    if (LEVEL) irr_d = ir_s;
    else       irr_d = (irr_q | (ir_s & ~ir_prev_q)) & ir_s;

    // EOI sees the pre-acknowledge ISR; a same-cycle ack set is applied afterwards.
    if (SEOI_CMD) begin
      isr_d[EOI_LEVEL] = 1'b0;
      if (R) lp_d = EOI_LEVEL;
    end else if (EOI_CMD && top_found) begin
      isr_d[top_idx] = 1'b0;
      if (R) lp_d = top_idx;
    end

    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d = ACK1;
          spur_d  = ~win_found;
          if (win_found) begin
            ir_num_d       = win_idx;
            isr_d[win_idx] = 1'b1;
            if (!LEVEL) irr_d[win_idx] = 1'b0;
          end else begin
            ir_num_d = 3'd7;
          end
        end else begin
          int_d = win_found && (!top_found || (win_rank < top_rank));
        end
      end
      ACK1: begin
        if (inta_fall) begin
          state_d = IDLE;
          if (AEOI && !spur_q) begin
            isr_d[ir_num_q] = 1'b0;
            if (R) lp_d = ir_num_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ir_sync_q   <= '0;
      inta_sync_q <= '0;
      ir_prev_q   <= '0;
      inta_prev_q <= 1'b0;
      irr_q       <= '0;
      isr_q       <= '0;
      lp_q        <= RESET_LP;
      ir_num_q    <= '0;
      int_q       <= 1'b0;
      spur_q      <= 1'b0;
      state_q     <= IDLE;
    end else begin
      ir_sync_q   <= {ir_sync_q[SYNC_STAGES-2:0], IR_IN};
      inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], INTA_};
      ir_prev_q   <= ir_s;
      inta_prev_q <= inta_s;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      lp_q        <= lp_d;
      ir_num_q    <= ir_num_d;
      int_q       <= int_d;
      spur_q      <= spur_d;
      state_q     <= state_d;
    end
  end

  assign INTERNAL_INT = int_q;
  assign IR_NUM       = ir_num_q;
  assign IRR_OUT      = irr_q;
  assign ISR_OUT      = isr_q;
  assign READ_DATA    = RISR ? isr_q : (RIRR ? irr_q : 8'h00);

endmodule

// File: tb/tb_pic_priority_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural 8259 model.
module tb_pic_priority_unit;

  localparam int SYNC = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] IR_IN = 8'h00;
  logic       LEVEL = 1'b0;
  logic [7:0] interrupt_mask = 8'h00;
  logic       INTA_ = 1'b1;
  logic       AEOI = 1'b0;
  logic       R = 1'b0;
  logic       EOI_CMD = 1'b0;
  logic       SEOI_CMD = 1'b0;
  logic [2:0] EOI_LEVEL = 3'd0;
  logic       RIRR = 1'b0;
  logic       RISR = 1'b0;
  logic       INTERNAL_INT;
  logic [2:0] IR_NUM;
  logic [7:0] IRR_OUT;
  logic [7:0] ISR_OUT;
  logic [7:0] READ_DATA;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  pic_priority_unit #(.SYNC_STAGES(SYNC), .RESET_LP(3'd7)) dut (
    .CLK(CLK), .RST(RST), .IR_IN(IR_IN), .LEVEL(LEVEL),
    .interrupt_mask(interrupt_mask), .INTA_(INTA_), .AEOI(AEOI), .R(R),
    .EOI_CMD(EOI_CMD), .SEOI_CMD(SEOI_CMD), .EOI_LEVEL(EOI_LEVEL),
    .RIRR(RIRR), .RISR(RISR), .INTERNAL_INT(INTERNAL_INT), .IR_NUM(IR_NUM),
    .IRR_OUT(IRR_OUT), .ISR_OUT(ISR_OUT), .READ_DATA(READ_DATA)
  );

  always #5 CLK = ~CLK;

  // Behavioural model state: what the PIC registers should hold after each edge.
  logic [7:0] mIrr, mIsr;
  int         mLp;
  logic       mInt;
  logic [2:0] mIrNum;
  bit         mInAck, mSpur;
  logic [7:0] irHist[$];
  bit         intaHist[$];

  function automatic int bestLevel(logic [7:0] v, int lp);
    for (int p = 1; p <= 8; p++) begin
      int l;
      l = (lp + p) % 8;
      if (v[l]) return l;
    end
    return -1;
  endfunction

  function automatic int rankOf(int l, int lp);
    return (l - lp - 1 + 16) % 8;
  endfunction

  function void checkVal(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic modelStep();
    logic [7:0] irNow, irOld, cand, nIrr, nIsr;
    bit   intaNow, intaOld, fall, nInt, nAck, nSpur;
    int   win, top, nLp;
    logic [2:0] nIrNum;
    irNow   = irHist[SYNC-1];
    irOld   = irHist[SYNC];
    intaNow = intaHist[SYNC-1];
    intaOld = intaHist[SYNC];
    fall    = intaOld && !intaNow;
    cand    = mIrr & ~interrupt_mask;
    win     = bestLevel(cand, mLp);
    top     = bestLevel(mIsr, mLp);
    nIsr = mIsr; nLp = mLp; nInt = 0; nIrNum = mIrNum; nAck = mInAck; nSpur = mSpur;
    if (LEVEL) nIrr = irNow;
    else for (int b = 0; b < 8; b++) nIrr[b] = irNow[b] && (mIrr[b] || !irOld[b]);
    if (SEOI_CMD) begin
      nIsr[EOI_LEVEL] = 1'b0;
      if (R) nLp = int'(EOI_LEVEL);
    end else if (EOI_CMD && top >= 0) begin
      nIsr[top] = 1'b0;
      if (R) nLp = top;
    end
    if (!mInAck) begin
      if (fall) begin
        nAck = 1;
        if (win >= 0) begin
          nIrNum = 3'(win);
          nIsr[win] = 1'b1;
          if (!LEVEL) nIrr[win] = 1'b0;
          nSpur = 0;
        end else begin
          nIrNum = 3'd7;
          nSpur = 1;
        end
      end else begin
        nInt = (win >= 0) && (top < 0 || rankOf(win, mLp) < rankOf(top, mLp));
      end
    end else if (fall) begin
      nAck = 0;
      if (AEOI && !mSpur) begin
        nIsr[mIrNum] = 1'b0;
        if (R) nLp = int'(mIrNum);
      end
    end
    mIrr = nIrr; mIsr = nIsr; mLp = nLp; mInt = nInt;
    mIrNum = nIrNum; mInAck = nAck; mSpur = nSpur;
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      mIrr = 0; mIsr = 0; mLp = 7; mInt = 0; mIrNum = 0; mInAck = 0; mSpur = 0;
      irHist = {};
      intaHist = {};
      for (int i = 0; i <= SYNC; i++) begin
        irHist.push_back(8'h00);
        intaHist.push_back(1'b0);
      end
      started = 1;
    end else if (started) begin
      modelStep();
      irHist.push_front(IR_IN);
      void'(irHist.pop_back());
      intaHist.push_front(INTA_);
      void'(intaHist.pop_back());
    end
  end

  // Every cycle, away from the rising edge, the DUT must match the model.
  always @(negedge CLK) begin
    if (started) begin
      checkVal("INTERNAL_INT", {7'b0, INTERNAL_INT}, {7'b0, mInt});
      checkVal("IR_NUM", {5'b0, IR_NUM}, {5'b0, mIrNum});
      checkVal("IRR_OUT", IRR_OUT, mIrr);
      checkVal("ISR_OUT", ISR_OUT, mIsr);
      checkVal("READ_DATA", READ_DATA, RISR ? mIsr : (RIRR ? mIrr : 8'h00));
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic applyStimulus_reset();
    RST = 1'b1; IR_IN = 8'h00; LEVEL = 1'b0; interrupt_mask = 8'h00; INTA_ = 1'b1;
    AEOI = 1'b0; R = 1'b0; EOI_CMD = 1'b0; SEOI_CMD = 1'b0; RIRR = 1'b0; RISR = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(3);
  endtask

  task automatic applyStimulus_inta();
    INTA_ = 1'b0;
    tick(4);
    INTA_ = 1'b1;
    tick(4);
  endtask

  task automatic applyStimulus_eoi();
    EOI_CMD = 1'b1;
    tick(1);
    EOI_CMD = 1'b0;
  endtask

  task automatic checkOutput(string name, logic [7:0] act, logic [7:0] exp);
    checkVal(name, act, exp);
  endtask

  int intaHold;

  initial begin
    // Reset state and basic edge-triggered request on IR3.
    applyStimulus_reset();
    checkOutput("rst_int", {7'b0, INTERNAL_INT}, 8'h00);
    checkOutput("rst_irnum", {5'b0, IR_NUM}, 8'h00);
    checkOutput("rst_isr", ISR_OUT, 8'h00);
    checkOutput("rst_irr", IRR_OUT, 8'h00);
    IR_IN = 8'h08;
    tick(4);
    checkOutput("ir3_int", {7'b0, INTERNAL_INT}, 8'h01);
    applyStimulus_inta();
    applyStimulus_inta();
    checkOutput("ir3_irnum", {5'b0, IR_NUM}, 8'h03);
    checkOutput("ir3_isr", ISR_OUT, 8'h08);
    checkOutput("ir3_irr", IRR_OUT, 8'h00);
    checkOutput("ir3_int_low", {7'b0, INTERNAL_INT}, 8'h00);
    RISR = 1'b1; #1;
    checkOutput("read_isr", READ_DATA, 8'h08);
    RISR = 1'b0;

    // Fixed priority and nesting.
    applyStimulus_reset();
    IR_IN = 8'h24;
    tick(4);
    applyStimulus_inta();
    applyStimulus_inta();
    checkOutput("fn_irnum", {5'b0, IR_NUM}, 8'h02);
    RIRR = 1'b1; #1;
    checkOutput("read_irr", READ_DATA, 8'h20);
    RISR = 1'b1; #1;
    checkOutput("read_both", READ_DATA, 8'h04);
    RIRR = 1'b0; RISR = 1'b0;
    IR_IN = 8'h64;
    tick(4);
    checkOutput("ir6_no_nest", {7'b0, INTERNAL_INT}, 8'h00);
    IR_IN = 8'h66;
    tick(4);
    checkOutput("ir1_nest", {7'b0, INTERNAL_INT}, 8'h01);

    // Rotation on EOI.
    applyStimulus_reset();
    R = 1'b1;
    IR_IN = 8'h10;
    tick(4);
    applyStimulus_inta();
    applyStimulus_inta();
    checkOutput("rot_irnum4", {5'b0, IR_NUM}, 8'h04);
    applyStimulus_eoi();
    checkOutput("rot_eoi_isr", ISR_OUT, 8'h00);
    IR_IN = 8'h00;
    tick(4);
    IR_IN = 8'h30;
    tick(4);
    applyStimulus_inta();
    applyStimulus_inta();
    checkOutput("rot_irnum5", {5'b0, IR_NUM}, 8'h05);
    R = 1'b0;

    // Automatic EOI.
    applyStimulus_reset();
    AEOI = 1'b1;
    IR_IN = 8'h01;
    tick(4);
    INTA_ = 1'b0; tick(4);
    checkOutput("aeoi_first", ISR_OUT, 8'h01);
    INTA_ = 1'b1; tick(4);
    INTA_ = 1'b0; tick(4);
    checkOutput("aeoi_second", ISR_OUT, 8'h00);
    INTA_ = 1'b1; tick(4);
    AEOI = 1'b0;

    // Spurious: request vanishes, then everything masked.
    applyStimulus_reset();
    IR_IN = 8'h40; tick(4);
    IR_IN = 8'h00; tick(4);
    applyStimulus_inta();
    applyStimulus_inta();
    checkOutput("spur_irnum", {5'b0, IR_NUM}, 8'h07);
    checkOutput("spur_isr", ISR_OUT, 8'h00);
    interrupt_mask = 8'hFF;
    IR_IN = 8'h02; tick(4);
    checkOutput("mask_int", {7'b0, INTERNAL_INT}, 8'h00);
    applyStimulus_inta();
    applyStimulus_inta();
    checkOutput("mask_irnum", {5'b0, IR_NUM}, 8'h07);
    checkOutput("mask_isr", ISR_OUT, 8'h00);
    interrupt_mask = 8'h00;

    // Level mode: held IR7 re-requests once its ISR bit clears.
    applyStimulus_reset();
    LEVEL = 1'b1;
    IR_IN = 8'h80; tick(4);
    applyStimulus_inta();
    applyStimulus_inta();
    checkOutput("lvl_isr", ISR_OUT, 8'h80);
    checkOutput("lvl_int_low", {7'b0, INTERNAL_INT}, 8'h00);
    applyStimulus_eoi();
    tick(1);
    checkOutput("lvl_reassert", {7'b0, INTERNAL_INT}, 8'h01);
    LEVEL = 1'b0;

    // Reset between the two acknowledge pulses.
    applyStimulus_reset();
    IR_IN = 8'h08; tick(4);
    INTA_ = 1'b0; tick(4);
    checkOutput("mid_isr_set", ISR_OUT, 8'h08);
    RST = 1'b1; tick(1); RST = 1'b0;
    checkOutput("mid_rst_isr", ISR_OUT, 8'h00);
    checkOutput("mid_rst_int", {7'b0, INTERNAL_INT}, 8'h00);
    checkOutput("mid_rst_irnum", {5'b0, IR_NUM}, 8'h00);
    INTA_ = 1'b1;
    tick(4);

    // Random traffic; the per-cycle compare process does the checking.
    intaHold = 0;
    for (int c = 0; c < 4000; c++) begin
      EOI_CMD = 1'b0;
      SEOI_CMD = 1'b0;
      RST = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 4) == 0) IR_IN = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0)
        interrupt_mask = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 399) == 0) LEVEL = ~LEVEL;
      if ($urandom_range(0, 99) == 0) R = ~R;
      if ($urandom_range(0, 99) == 0) AEOI = ~AEOI;
      if ($urandom_range(0, 19) == 0) EOI_CMD = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        SEOI_CMD = 1'b1;
        EOI_LEVEL = 3'($urandom_range(0, 7));
      end
      RISR = ($urandom_range(0, 2) == 0);
      RIRR = ($urandom_range(0, 1) == 0);
      if (intaHold > 0) intaHold--;
      else if (INTA_ == 1'b0) begin
        INTA_ = 1'b1;
        intaHold = 3 + int'($urandom_range(0, 6));
      end else if ($urandom_range(0, 5) == 0) begin
        INTA_ = 1'b0;
        intaHold = 3 + int'($urandom_range(0, 3));
      end
      tick(1);
    end
    RST = 1'b0;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
